// File: rtl/inst_fetch.sv
// IF stage of the 5-stage MIPS pipeline: fetch PC, imem req/ack handshake and the IF/ID register.
// Redirects taken before their delay slot is fetched are parked in redir_pend_q until that slot is delivered.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        id_stall_i,
   input  logic [1:0]  pc_src_i,
   input  logic [31:0] id_data_rs_i,
   input  logic        exc_en_i,
   input  logic [31:0] exc_target_i,
   output logic        id_valid_o,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o,
   output logic        id_misalign_o,
   output logic        if_busy_o
);
   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;
   localparam logic [1:0] SRC_JUMP = 2'd1, SRC_JR = 2'd2, SRC_BRANCH = 2'd3;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        redir_pend_q, redir_pend_d;
   logic        id_valid_q, id_valid_d;
   logic        id_mis_q, id_mis_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        pc_misal, ack, take_now, deliver;
   logic [31:0] id_pc4, target, dlv_inst;

   assign pc_misal    = (pc_q[1:0] != 2'b00);
   assign imem_req_o  = ~rst & (((state_q == S_FETCH) & ~pc_misal) | (state_q == S_DROP));
   // While dropping, pc_q already holds the exception target; keep showing the in-flight address.
   assign imem_addr_o = (state_q == S_DROP) ? drop_addr_q : pc_q;
   assign ack         = imem_req_o & imem_ack_i;
   assign if_busy_o   = imem_req_o & ~imem_ack_i;

   assign id_valid_o    = id_valid_q;
   assign id_inst_o     = id_inst_q;
   assign id_pc_o       = id_pc_q;
   assign id_misalign_o = id_mis_q;

   assign id_pc4   = id_pc_q + 32'd4;
   assign take_now = id_valid_q & ~id_stall_i & (pc_src_i != 2'd0);

   always_comb begin
      case (pc_src_i)
         SRC_JUMP:   target = {id_pc4[31:28], id_inst_q[25:0], 2'b00};
         SRC_JR:     target = id_data_rs_i;
         SRC_BRANCH: target = id_pc4 + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
         default:    target = id_pc4;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      buf_d        = buf_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      id_valid_d   = id_valid_q;
      id_inst_d    = id_inst_q;
      id_pc_d      = id_pc_q;
      id_mis_d     = id_mis_q;
      deliver      = 1'b0;
      dlv_inst     = imem_data_i;

      case (state_q)
         S_FETCH: begin
            if (pc_misal) begin
               if (!id_stall_i) begin
                  id_valid_d = 1'b1;
                  id_inst_d  = 32'd0;
                  id_pc_d    = pc_q;
                  id_mis_d   = 1'b1;
               end
            end else if (ack && !id_stall_i) begin
               deliver = 1'b1;
            end else if (ack) begin
               buf_d   = imem_data_i;
               state_d = S_HOLD;
            end else if (!id_stall_i) begin
               id_valid_d = 1'b0;
               id_inst_d  = 32'd0;
               id_mis_d   = 1'b0;
            end
         end
         S_HOLD: begin
            if (!id_stall_i) begin
               deliver  = 1'b1;
               dlv_inst = buf_q;
               state_d  = S_FETCH;
            end
         end
         S_DROP: begin
            if (ack) state_d = S_FETCH;
            if (!id_stall_i) begin
               id_valid_d = 1'b0;
               id_inst_d  = 32'd0;
               id_mis_d   = 1'b0;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // The word delivered here is the delay slot of any branch ID resolves this cycle.
      if (deliver) begin
         id_valid_d   = 1'b1;
         id_inst_d    = dlv_inst;
         id_pc_d      = pc_q;
         id_mis_d     = 1'b0;
         redir_pend_d = 1'b0;
         if (take_now)          pc_d = target;
         else if (redir_pend_q) pc_d = redir_pc_q;
         else                   pc_d = pc_q + 32'd4;
      end else if (take_now) begin
         redir_pc_d   = target;
         redir_pend_d = 1'b1;
      end

      if (exc_en_i) begin
         id_valid_d   = 1'b0;
         id_inst_d    = 32'd0;
         id_mis_d     = 1'b0;
         redir_pend_d = 1'b0;
         pc_d         = exc_target_i;
         case (state_q)
            S_FETCH: begin
               if (imem_req_o && !ack) begin
                  state_d     = S_DROP;
                  drop_addr_d = pc_q;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_DROP:  state_d = ack ? S_FETCH : S_DROP;
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         drop_addr_q  <= 32'd0;
         buf_q        <= 32'd0;
         redir_pc_q   <= 32'd0;
         redir_pend_q <= 1'b0;
         id_valid_q   <= 1'b0;
         id_inst_q    <= 32'd0;
         id_pc_q      <= 32'd0;
         id_mis_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         buf_q        <= buf_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         id_valid_q   <= id_valid_d;
         id_inst_q    <= id_inst_d;
         id_pc_q      <= id_pc_d;
         id_mis_q     <= id_mis_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: the bench plays imem and the ID controller, and tracks the expected
// program-order stream of delivered PCs (delay slots, redirects, exceptions) at transaction level.
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o, imem_ack_i, id_stall_i, exc_en_i;
   logic [31:0] imem_addr_o, imem_data_i, id_data_rs_i, exc_target_i;
   logic [1:0]  pc_src_i;
   logic        id_valid_o, id_misalign_o, if_busy_o;
   logic [31:0] id_inst_o, id_pc_o;

   inst_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
      .id_stall_i(id_stall_i), .pc_src_i(pc_src_i), .id_data_rs_i(id_data_rs_i),
      .exc_en_i(exc_en_i), .exc_target_i(exc_target_i),
      .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
      .id_misalign_o(id_misalign_o), .if_busy_o(if_busy_o)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // reference model state
   logic [31:0] mem_ovr [logic [31:0]];
   logic [31:0] exp_next = 32'd0;      // PC of the next instruction to arrive in IF/ID
   logic        pend = 1'b0;           // a taken branch redirects after the next delivery
   logic [31:0] pend_tgt = 32'd0;
   logic        last_taken = 1'b0;     // next consumed instruction is a delay slot
   logic        cur_valid = 1'b0, cur_mis = 1'b0;
   logic [31:0] cur_pc = 32'd0;
   logic        req_pend = 1'b0;
   logic [31:0] req_addr = 32'd0, last_addr = 32'd0;
   int          wait_cnt = 0, idle = 0;

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (mem_ovr.exists(a)) return mem_ovr[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic stall, input logic [1:0] src, input logic [31:0] rs,
                       input logic exc, input logic [31:0] etgt, input int ack_pct);
      logic        pre_req, ack, consume, take;
      logic [31:0] pre_addr, tgt, inst_c, pc4;
      logic [1:0]  drv;
      @(negedge clk);
      pre_req  = imem_req_o;
      pre_addr = imem_addr_o;
      if (req_pend) begin
         chk("req_held", 32'(pre_req), 32'd1);
         chk("addr_held", pre_addr, req_addr);
      end
      if (pre_req) chk("req_aligned", 32'(pre_addr[1:0]), 32'd0);
      ack     = pre_req && (($urandom_range(99) < ack_pct) || wait_cnt >= 8);
      consume = cur_valid && !stall;
      drv     = (cur_valid && (cur_mis || last_taken)) ? 2'd0 : src;
      take    = consume && (drv != 2'd0) && !exc;
      inst_c  = memw(cur_pc);
      pc4     = cur_pc + 32'd4;
      case (drv)
         2'd1:    tgt = {pc4[31:28], inst_c[25:0], 2'b00};
         2'd2:    tgt = rs;
         default: tgt = pc4 + 32'(int'($signed(inst_c[15:0])) * 4);
      endcase
      id_stall_i   = stall;
      pc_src_i     = drv;
      id_data_rs_i = rs;
      exc_en_i     = exc;
      exc_target_i = etgt;
      imem_ack_i   = ack;
      imem_data_i  = ack ? memw(pre_addr) : $urandom;
      #1 chk("if_busy", 32'(if_busy_o), 32'(pre_req && !ack));
      @(posedge clk);
      #1;
      last_addr = pre_addr;
      req_pend  = pre_req && !ack;
      req_addr  = pre_addr;
      wait_cnt  = req_pend ? wait_cnt + 1 : 0;
      if (exc) begin
         chk("exc_bubble_v", 32'(id_valid_o), 32'd0);
         chk("exc_bubble_i", id_inst_o, 32'd0);
         exp_next = etgt; pend = 1'b0; last_taken = 1'b0; cur_valid = 1'b0; idle = 0;
      end else begin
         if (take) begin
            pend = 1'b1; pend_tgt = tgt; last_taken = 1'b1;
         end else if (consume) begin
            last_taken = 1'b0;
         end
         if (stall) begin
            chk("hold_valid", 32'(id_valid_o), 32'(cur_valid));
            if (cur_valid) begin
               chk("hold_pc", id_pc_o, cur_pc);
               chk("hold_inst", id_inst_o, cur_mis ? 32'd0 : memw(cur_pc));
               chk("hold_mis", 32'(id_misalign_o), 32'(cur_mis));
            end
            idle = 0;
         end else if (id_valid_o) begin
            chk("dlv_pc", id_pc_o, exp_next);
            cur_valid = 1'b1;
            cur_pc    = exp_next;
            cur_mis   = (exp_next[1:0] != 2'b00);
            chk("dlv_mis", 32'(id_misalign_o), 32'(cur_mis));
            chk("dlv_inst", id_inst_o, cur_mis ? 32'd0 : memw(exp_next));
            if (!cur_mis) begin
               exp_next = pend ? pend_tgt : exp_next + 32'd4;
               pend     = 1'b0;
            end
            idle = 0;
         end else begin
            chk("bubble_inst", id_inst_o, 32'd0);
            cur_valid = 1'b0;
            idle++;
            if (idle == 30) chk("progress_timeout", 32'(idle), 32'd0);
         end
      end
   endtask

   task automatic redirect(input logic [31:0] t);
      tick(1'b0, 2'd0, 32'd0, 1'b1, t, 100);
      for (int i = 0; i < 12; i++) begin
         if (cur_valid && cur_pc == t) break;
         tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      end
      chk("redir_reached", id_pc_o, t);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; imem_ack_i = 1'b0; imem_data_i = 32'd0; id_stall_i = 1'b0;
      pc_src_i = 2'd0; id_data_rs_i = 32'd0; exc_en_i = 1'b0; exc_target_i = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      chk("rst_inst", id_inst_o, 32'd0);
      chk("rst_pc", id_pc_o, 32'd0);
      chk("rst_mis", 32'(id_misalign_o), 32'd0);
      chk("rst_busy", 32'(if_busy_o), 32'd0);
      rst = 1'b0;

      // straight-line fetch from reset, imem always acking
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
         chk("seq_addr", last_addr, 32'(i * 4));
      end

      // BEQ at 0x100 taken with imm=3
      mem_ovr[32'h100] = 32'h1000_0003;
      redirect(32'h100);
      tick(1'b0, 2'd3, 32'd0, 1'b0, 32'd0, 100);
      chk("beq_slot_pc", id_pc_o, 32'h104);
      chk("beq_next_addr", imem_addr_o, 32'h110);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);

      // JR at 0x200 with the delay-slot ack held off for 3 cycles
      redirect(32'h200);
      tick(1'b0, 2'd2, 32'h400, 1'b0, 32'd0, 0);
      chk("jr_slot_addr", imem_addr_o, 32'h204);
      repeat (2) tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 0);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      chk("jr_next_addr", imem_addr_o, 32'h400);

      // ID stalls for 4 cycles while the word at 0x400 arrives
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 2'd0, 32'd0, 1'b0, 32'd0, 100);
         chk("hold_noreq", 32'(imem_req_o), 32'd0);
      end
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      chk("hold_release_pc", id_pc_o, 32'h400);

      // exception while a fetch is outstanding
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 0);
      tick(1'b0, 2'd0, 32'd0, 1'b1, 32'h80, 0);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 0);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      chk("drop_next_addr", imem_addr_o, 32'h80);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);

      // JR to a misaligned target parks fetch until the next exception
      tick(1'b0, 2'd2, 32'h302, 1'b0, 32'd0, 100);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      chk("mis_noreq", 32'(imem_req_o), 32'd0);
      chk("mis_flag", 32'(id_misalign_o), 32'd1);
      chk("mis_inst", id_inst_o, 32'd0);
      tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      redirect(32'h500);

      // address wrap at the top of the space
      redirect(32'hFFFF_FFF8);
      repeat (2) tick(1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 100);
      chk("wrap_pc", id_pc_o, 32'd0);

      // randomized traffic against the reference model
      for (int n = 0; n < 2000; n++) begin
         logic        st, ex;
         logic [1:0]  s;
         logic [31:0] r, et;
         st = ($urandom_range(3) == 0);
         s  = ($urandom_range(9) < 3) ? 2'($urandom_range(3)) : 2'd0;
         r  = $urandom & ~32'h3;
         if ($urandom_range(15) == 0) r = r | 32'($urandom_range(3));
         ex = (cur_valid && cur_mis) ? ($urandom_range(2) == 0) : ($urandom_range(49) == 0);
         et = $urandom & ~32'h3;
         tick(st, s, r, ex, et, 60);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
